// File: rtl/eth_uart_bridge_top.sv
`default_nettype none
// ==========================================================================
// eth_uart_bridge_top : RMII port-1 frame counter, UART byte reporter, LEDs
// Revision 1.0
// ==========================================================================
module eth_uart_bridge_top #(
    parameter int CLK_HZ  = 200_000_000,
    parameter int BAUD    = 115200,
    parameter int ETH_DIV = 4
) (
    input  logic       clk_200_mhz,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    input  logic       crs_dv_1,
    input  logic [1:0] rx_d_1,
    input  logic       rx_er_1,
    output logic [1:0] tx_d_1,
    output logic       tx_e_1,
    output logic       clk_50_mhz_1,
    output logic       rst_n_1,
    output logic       mdc_1,
    inout  wire        mdio_1,
    input  logic       crs_dv_2,
    input  logic [1:0] rx_d_2,
    input  logic       rx_er_2,
    output logic [1:0] tx_d_2,
    output logic       tx_e_2,
    output logic       clk_50_mhz_2,
    output logic       rst_n_2,
    output logic       mdc_2,
    inout  wire        mdio_2,
    input  logic       btn,
    output logic [7:0] led
);
    localparam int c_BIT  = CLK_HZ / BAUD;
    localparam int c_CW   = $clog2(c_BIT);
    localparam int c_DW   = $clog2(ETH_DIV);
    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(c_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_DATA = 2'd2} rmii_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3} urx_state_t;
    typedef enum logic {T_IDLE = 1'b0, T_SEND = 1'b1} utx_state_t;

    logic [c_DW-1:0] r_div;
    logic            r_phy_rst_n;
    logic            r_crs, r_rxer;
    logic [1:0]      r_rxd;
    rmii_state_t     r_state, w_state_nxt;
    logic [1:0]      r_phase;
    logic [15:0]     r_byte_cnt;
    logic            r_err;
    logic [7:0]      r_frame_cnt;
    logic            w_se, w_good;
    logic            w_unused_port2;

    assign w_se           = (r_div == '0);
    assign w_unused_port2 = ^{crs_dv_2, rx_d_2, rx_er_2};

    always_ff @(posedge clk_200_mhz) begin
        if (!rst) begin
            r_div       <= '0;
            r_phy_rst_n <= 1'b0;
            r_crs       <= 1'b0;
            r_rxd       <= 2'b00;
            r_rxer      <= 1'b0;
        end else begin
            r_div       <= (r_div == c_DW'(ETH_DIV - 1)) ? '0 : r_div + c_DW'(1);
            r_phy_rst_n <= 1'b1;
            r_crs       <= crs_dv_1;
            r_rxd       <= rx_d_1;
            r_rxer      <= rx_er_1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_se) begin
            if (!r_crs) begin
                w_state_nxt = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE:  if (r_rxd == 2'b01) w_state_nxt = S_PRE;
                    S_PRE:   if (r_rxd == 2'b11) w_state_nxt = S_DATA;
                             else if (r_rxd != 2'b01) w_state_nxt = S_IDLE;
                    default: w_state_nxt = S_DATA;
                endcase
            end
        end
    end

    // A frame counts only if it ended on a byte boundary with no receive error.
    assign w_good = w_se && (r_state == S_DATA) && !r_crs &&
                    (r_byte_cnt != 16'd0) && (r_phase == 2'd0) && !r_err;

    always_ff @(posedge clk_200_mhz) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_phase     <= 2'd0;
            r_byte_cnt  <= 16'd0;
            r_err       <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_se) begin
                if (r_state == S_IDLE && w_state_nxt == S_PRE) begin
                    r_phase    <= 2'd0;
                    r_byte_cnt <= 16'd0;
                    r_err      <= 1'b0;
                end
                if (r_state != S_IDLE && r_crs && r_rxer)
                    r_err <= 1'b1;
                if (r_state == S_DATA && r_crs) begin
                    r_phase <= r_phase + 2'd1;
                    if (r_phase == 2'd3)
                        r_byte_cnt <= r_byte_cnt + 16'd1;
                end
            end
            if (w_good)
                r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    urx_state_t      r_urx_state, w_urx_nxt;
    logic            r_rx_s1, r_rx_s2, r_rx_prev;
    logic [c_CW-1:0] r_urx_cnt;
    logic [2:0]      r_urx_bits;
    logic [7:0]      r_urx_shift, r_uart_byte;

    always_comb begin
        w_urx_nxt = r_urx_state;
        case (r_urx_state)
            R_IDLE:  if (r_rx_prev && !r_rx_s2) w_urx_nxt = R_START;
            R_START: if (r_urx_cnt == c_HALF_LAST) w_urx_nxt = r_rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (r_urx_cnt == c_BIT_LAST && r_urx_bits == 3'd7) w_urx_nxt = R_STOP;
            default: if (r_urx_cnt == c_BIT_LAST) w_urx_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_200_mhz) begin
        if (!rst) begin
            r_urx_state <= R_IDLE;
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_urx_cnt   <= '0;
            r_urx_bits  <= 3'd0;
            r_urx_shift <= 8'd0;
            r_uart_byte <= 8'd0;
        end else begin
            r_urx_state <= w_urx_nxt;
            r_rx_s1     <= uart_rx;
            r_rx_s2     <= r_rx_s1;
            r_rx_prev   <= r_rx_s2;
            if (r_urx_state == R_IDLE || w_urx_nxt != r_urx_state || r_urx_cnt == c_BIT_LAST)
                r_urx_cnt <= '0;
            else
                r_urx_cnt <= r_urx_cnt + c_CW'(1);
            if (r_urx_state == R_START)
                r_urx_bits <= 3'd0;
            if (r_urx_state == R_DATA && r_urx_cnt == c_BIT_LAST) begin
                r_urx_shift <= {r_rx_s2, r_urx_shift[7:1]};
                r_urx_bits  <= r_urx_bits + 3'd1;
            end
            if (r_urx_state == R_STOP && r_urx_cnt == c_BIT_LAST && r_rx_s2)
                r_uart_byte <= r_urx_shift;
        end
    end

    utx_state_t      r_utx_state, w_utx_nxt;
    logic [7:0]      r_hold;
    logic            r_hold_v;
    logic [9:0]      r_tx_shift;
    logic [3:0]      r_tx_bits;
    logic [c_CW-1:0] r_tx_cnt;

    always_comb begin
        w_utx_nxt = r_utx_state;
        case (r_utx_state)
            T_IDLE:  if (r_hold_v) w_utx_nxt = T_SEND;
            default: if (r_tx_cnt == c_BIT_LAST && r_tx_bits == 4'd9) w_utx_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk_200_mhz) begin
        if (!rst) begin
            r_utx_state <= T_IDLE;
            r_hold      <= 8'd0;
            r_hold_v    <= 1'b0;
            r_tx_shift  <= 10'h3FF;
            r_tx_bits   <= 4'd0;
            r_tx_cnt    <= '0;
        end else begin
            r_utx_state <= w_utx_nxt;
            // A fresh report always wins over the pending one.
            if (w_good) begin
                r_hold   <= r_byte_cnt[7:0];
                r_hold_v <= 1'b1;
            end else if (r_utx_state == T_IDLE) begin
                r_hold_v <= 1'b0;
            end
            if (r_utx_state == T_IDLE) begin
                r_tx_cnt  <= '0;
                r_tx_bits <= 4'd0;
                if (r_hold_v)
                    r_tx_shift <= {1'b1, r_hold, 1'b0};
            end else if (r_tx_cnt == c_BIT_LAST) begin
                r_tx_cnt   <= '0;
                r_tx_bits  <= r_tx_bits + 4'd1;
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
            end else begin
                r_tx_cnt <= r_tx_cnt + c_CW'(1);
            end
        end
    end

    always_ff @(posedge clk_200_mhz) begin
        if (!rst)
            led <= 8'd0;
        else
            led <= btn ? r_frame_cnt : r_uart_byte;
    end

    assign uart_tx      = (r_utx_state == T_SEND) ? r_tx_shift[0] : 1'b1;
    assign clk_50_mhz_1 = (r_div >= c_DW'(ETH_DIV / 2));
    assign clk_50_mhz_2 = clk_50_mhz_1;
    assign rst_n_1      = r_phy_rst_n;
    assign rst_n_2      = r_phy_rst_n;
    assign tx_d_1       = 2'b00;
    assign tx_d_2       = 2'b00;
    assign tx_e_1       = 1'b0;
    assign tx_e_2       = 1'b0;
    assign mdc_1        = 1'b0;
    assign mdc_2        = 1'b0;
    assign mdio_1       = 1'bz;
    assign mdio_2       = 1'bz;
endmodule
`default_nettype wire

// File: tb/tb_eth_uart_bridge_top.sv
`default_nettype none
// ==========================================================================
// tb_eth_uart_bridge_top : randomized self-checking bench for the bridge top
// Revision 1.0
// ==========================================================================
module tb_eth_uart_bridge_top;
    localparam int BIT = 1736;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_rx = 1'b1;
    logic       crs_dv_1 = 1'b0, rx_er_1 = 1'b0, crs_dv_2 = 1'b0, rx_er_2 = 1'b0;
    logic [1:0] rx_d_1 = 2'b00, rx_d_2 = 2'b00;
    logic       btn = 1'b0;
    logic       uart_tx, tx_e_1, tx_e_2, clk_50_mhz_1, clk_50_mhz_2;
    logic       rst_n_1, rst_n_2, mdc_1, mdc_2;
    logic [1:0] tx_d_1, tx_d_2;
    logic [7:0] led;
    wire        mdio_1, mdio_2;

    int n_cmp = 0;
    int n_bad = 0;
    int model_fc = 0;

    logic [1:0] dq[$];
    logic       eq[$];

    eth_uart_bridge_top dut (
        .clk_200_mhz(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .crs_dv_1(crs_dv_1), .rx_d_1(rx_d_1), .rx_er_1(rx_er_1), .tx_d_1(tx_d_1),
        .tx_e_1(tx_e_1), .clk_50_mhz_1(clk_50_mhz_1), .rst_n_1(rst_n_1), .mdc_1(mdc_1),
        .mdio_1(mdio_1),
        .crs_dv_2(crs_dv_2), .rx_d_2(rx_d_2), .rx_er_2(rx_er_2), .tx_d_2(tx_d_2),
        .tx_e_2(tx_e_2), .clk_50_mhz_2(clk_50_mhz_2), .rst_n_2(rst_n_2), .mdc_2(mdc_2),
        .mdio_2(mdio_2),
        .btn(btn), .led(led)
    );

    always #5 clk = ~clk;

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_dibit(input logic [1:0] d, input logic e);
        dq.push_back(d);
        eq.push_back(e);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) push_dibit(b[2*i +: 2], 1'b0);
    endtask

    task automatic push_preamble(input int n);
        for (int i = 0; i < n; i++) push_dibit(2'b01, 1'b0);
        push_dibit(2'b11, 1'b0);
    endtask

    // Each dibit is held for one 50 MHz period (4 system clocks).
    task automatic play_frame(input bit end_frame);
        for (int i = 0; i < dq.size(); i++) begin
            crs_dv_1 = 1'b1; rx_d_1 = dq[i]; rx_er_1 = eq[i];
            repeat (4) @(negedge clk);
        end
        dq.delete();
        eq.delete();
        if (end_frame) begin
            crs_dv_1 = 1'b0; rx_d_1 = 2'b00; rx_er_1 = 1'b0;
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = stop;
        repeat (BIT) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic capture_tx(output logic [7:0] b, output logic ok);
        int t;
        b  = 8'h00;
        ok = 1'b0;
        t  = 0;
        while (uart_tx !== 1'b0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) return;
        repeat (BIT / 2) @(negedge clk);
        if (uart_tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (BIT) @(negedge clk);
        ok = (uart_tx === 1'b1);
    endtask

    task automatic show(input logic sel);
        btn = sel;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        int   rises;
        logic prev;
        rst = 1'b0;
        repeat (100) @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL rst_uart_tx got %b want 1", uart_tx); end
        n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL rst_led got %h want 00", led); end
        n_cmp++; if (rst_n_1 !== 1'b0 || rst_n_2 !== 1'b0) begin n_bad++; $display("FAIL rst_phy got %b%b want 00", rst_n_1, rst_n_2); end
        n_cmp++; if (clk_50_mhz_1 !== 1'b0) begin n_bad++; $display("FAIL rst_clk50 got %b want 0", clk_50_mhz_1); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (rst_n_1 !== 1'b1 || rst_n_2 !== 1'b1) begin n_bad++; $display("FAIL rst_release got %b%b want 11", rst_n_1, rst_n_2); end
        rises = 0;
        prev  = clk_50_mhz_1;
        repeat (40) begin
            @(negedge clk);
            if (clk_50_mhz_1 && !prev) rises++;
            prev = clk_50_mhz_1;
        end
        n_cmp++; if (rises != 10) begin n_bad++; $display("FAIL clk50_rises got %0d want 10", rises); end
        n_cmp++; if (tx_d_1 !== 2'b00 || tx_e_1 !== 1'b0 || mdc_1 !== 1'b0 || tx_e_2 !== 1'b0)
            begin n_bad++; $display("FAIL idle_tx got %b %b %b want 00 0 0", tx_d_1, tx_e_1, mdc_1); end
        model_fc = 0;
    endtask

    task automatic test_uart_rx;
        logic [7:0] junk;
        show(1'b0);
        uart_send(8'h5A, 1'b1);
        n_cmp++; if (led !== 8'h5A) begin n_bad++; $display("FAIL uart_rx_good got %h want 5a", led); end
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'h5A) junk = 8'hA5;
        uart_send(junk, 1'b0);
        n_cmp++; if (led !== 8'h5A) begin n_bad++; $display("FAIL uart_rx_badstop got %h want 5a", led); end
        show(1'b1);
        n_cmp++; if (led !== 8'(model_fc)) begin n_bad++; $display("FAIL led_btn1 got %h want %h", led, 8'(model_fc)); end
    endtask

    task automatic test_good_frame;
        logic [7:0] b;
        logic       ok;
        show(1'b1);
        push_preamble(7);
        push_byte(8'hAB);
        push_byte(8'hCD);
        play_frame(1'b1);
        model_fc = (model_fc + 1) % 256;
        n_cmp++; if (led !== 8'(model_fc)) begin n_bad++; $display("FAIL good_frame_cnt got %h want %h", led, 8'(model_fc)); end
        capture_tx(b, ok);
        n_cmp++; if (!ok || b !== 8'h02) begin n_bad++; $display("FAIL good_frame_tx got %h ok=%b want 02", b, ok); end
    endtask

    task automatic test_bad_frames;
        int quiet;
        // Three data dibits leave the byte incomplete.
        push_preamble(7);
        push_dibit(2'b10, 1'b0); push_dibit(2'b00, 1'b0); push_dibit(2'b11, 1'b0);
        play_frame(1'b1);
        quiet = 1;
        repeat (300) begin @(negedge clk); if (uart_tx !== 1'b1) quiet = 0; end
        n_cmp++; if (quiet != 1) begin n_bad++; $display("FAIL odd_frame_tx got activity want idle"); end
        n_cmp++; if (led !== 8'(model_fc)) begin n_bad++; $display("FAIL odd_frame_cnt got %h want %h", led, 8'(model_fc)); end
        push_dibit(2'b01, 1'b0); push_dibit(2'b01, 1'b0); push_dibit(2'b10, 1'b0);
        push_byte(8'hAB);
        push_byte(8'hCD);
        play_frame(1'b1);
        quiet = 1;
        repeat (300) begin @(negedge clk); if (uart_tx !== 1'b1) quiet = 0; end
        n_cmp++; if (quiet != 1) begin n_bad++; $display("FAIL pre_err_tx got activity want idle"); end
        n_cmp++; if (led !== 8'(model_fc)) begin n_bad++; $display("FAIL pre_err_cnt got %h want %h", led, 8'(model_fc)); end
    endtask

    // Frame kinds: 0 good, 1 trailing partial byte, 2 rx_er inside data, 3 no data.
    task automatic test_random_frames;
        int typ, n, pre, first, idx;
        for (int k = 0; k < 16; k++) begin
            typ = (k < 4) ? k : int'($urandom_range(0, 3));
            n   = int'($urandom_range(1, 5));
            pre = int'($urandom_range(1, 7));
            if (typ == 3) n = 0;
            push_preamble(pre);
            first = dq.size();
            for (int j = 0; j < n; j++) push_byte(8'($urandom_range(0, 255)));
            if (typ == 1) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                    push_dibit(2'($urandom_range(0, 3)), 1'b0);
            end
            if (typ == 2) begin
                idx = first + int'($urandom_range(0, n * 4 - 1));
                eq[idx] = 1'b1;
            end
            play_frame(1'b1);
            if (typ == 0) model_fc = (model_fc + 1) % 256;
            n_cmp++;
            if (led !== 8'(model_fc)) begin
                n_bad++;
                $display("FAIL rand_frame_%0d type %0d got %h want %h", k, typ, led, 8'(model_fc));
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        logic       ok;
        push_preamble(7);
        push_byte(8'h3C);
        push_dibit(2'b01, 1'b0); push_dibit(2'b10, 1'b0);
        play_frame(1'b0);
        rst = 1'b0; crs_dv_1 = 1'b0; rx_d_1 = 2'b00;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        model_fc = 0;
        n_cmp++; if (led !== 8'h00 || uart_tx !== 1'b1) begin n_bad++; $display("FAIL midrst_state got led %h tx %b want 00 1", led, uart_tx); end
        push_preamble(7);
        push_byte(8'($urandom_range(0, 255)));
        play_frame(1'b1);
        model_fc = 1;
        n_cmp++; if (led !== 8'(model_fc)) begin n_bad++; $display("FAIL midrst_cnt got %h want %h", led, 8'(model_fc)); end
        capture_tx(b, ok);
        n_cmp++; if (!ok || b !== 8'h01) begin n_bad++; $display("FAIL midrst_tx got %h ok=%b want 01", b, ok); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_uart_rx();
        test_good_frame();
        test_bad_frames();
        test_random_frames();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
